sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_sram_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// SRAM arbiter: host slot accesses in S4-S6 with absolute priority, plus a
// block-fill engine that writes one byte per two clocks outside the host window.
module sram_arbiter (
  input  logic        C7M,
  input  logic        RES,
  input  logic [2:0]  S,
  input  logic        HREQ,
  input  logic        HWR,
  input  logic [19:0] HADDR,
  input  logic [7:0]  HWD,
  output logic [7:0]  HRD,
  input  logic [19:0] FADDR,
  input  logic [15:0] FLEN,
  input  logic [7:0]  FBYTE,
  input  logic        GO,
  input  logic        ABORT,
  output logic        BUSY,
  output logic        DONE,
  output logic [19:0] RA,
  output logic [7:0]  RDO,
  input  logic [7:0]  RDI,
  output logic        RDOE,
  output logic        RAMCS,
  output logic        nRWE
);

  typedef enum logic [1:0] {
    ENG_IDLE   = 2'd0,
    ENG_SETUP  = 2'd1,
    ENG_STROBE = 2'd2
  } eng_state_e;

  eng_state_e  eng_q, eng_d;
  logic        host_q, host_d;
  logic        hwr_q, hwr_d;
  logic [19:0] ptr_q, ptr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  val_q, val_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [19:0] ra_q, ra_d;
  logic [7:0]  rdo_q, rdo_d;
  logic [7:0]  hrd_q, hrd_d;
  logic        rdoe_q, rdoe_d;
  logic        ramcs_q, ramcs_d;
  logic        nrwe_q, nrwe_d;

  logic        slot_ok;
  logic [19:0] ptr_inc;
  logic [15:0] cnt_dec;

  // A two-clock access opened at S==1 or S==7 always ends before the S4 window.
  assign slot_ok = (S == 3'd1) || ((S == 3'd7) && !host_q);
  assign ptr_inc = ptr_q + 20'd1;
  assign cnt_dec = cnt_q - 16'd1;

  always_comb begin
    eng_d   = eng_q;
    host_d  = host_q;
    hwr_d   = hwr_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    busy_d  = busy_q;
    done_d  = done_q;
    ra_d    = ra_q;
    rdo_d   = rdo_q;
    hrd_d   = hrd_q;
    rdoe_d  = rdoe_q;
    ramcs_d = ramcs_q;
    nrwe_d  = nrwe_q;

    case (eng_q)
      ENG_IDLE: begin
        if (!busy_q) begin
          if (GO) begin
            ptr_d  = FADDR;
            cnt_d  = FLEN;
            val_d  = FBYTE;
            busy_d = 1'b1;
            done_d = 1'b0;
          end
        end else if (ABORT) begin
          busy_d = 1'b0;
        end else if (cnt_q == 16'd0) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else if (slot_ok) begin
          eng_d   = ENG_SETUP;
          ra_d    = ptr_q;
          rdo_d   = val_q;
          rdoe_d  = 1'b1;
          ramcs_d = 1'b1;
          nrwe_d  = 1'b1;
        end
      end
      ENG_SETUP: begin
        eng_d  = ENG_STROBE;
        nrwe_d = 1'b0;
      end
      ENG_STROBE: begin
        ptr_d   = ptr_inc;
        cnt_d   = cnt_dec;
        eng_d   = ENG_IDLE;
        ramcs_d = 1'b0;
        rdoe_d  = 1'b0;
        nrwe_d  = 1'b1;
        // Completion wins over a simultaneous abort: the last byte did land.
        if (cnt_dec == 16'd0) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else if (ABORT) begin
          busy_d = 1'b0;
        end else if (slot_ok) begin
          eng_d   = ENG_SETUP;
          ra_d    = ptr_inc;
          rdo_d   = val_q;
          rdoe_d  = 1'b1;
          ramcs_d = 1'b1;
        end
      end
      default: eng_d = ENG_IDLE;
    endcase

    // Host overlays the engine; the engine is never active while the host owns the bus.
    if (host_q) begin
      case (S)
        3'd4: if (hwr_q) nrwe_d = 1'b0;
        3'd5: nrwe_d = 1'b1;
        3'd6: begin
          if (!hwr_q) hrd_d = RDI;
          host_d  = 1'b0;
          ramcs_d = 1'b0;
          rdoe_d  = 1'b0;
          nrwe_d  = 1'b1;
        end
        default: ;
      endcase
    end else if ((S == 3'd3) && HREQ) begin
      host_d  = 1'b1;
      hwr_d   = HWR;
      ra_d    = HADDR;
      ramcs_d = 1'b1;
      rdoe_d  = HWR;
      nrwe_d  = 1'b1;
      if (HWR) rdo_d = HWD;
    end
  end

  always_ff @(posedge C7M) begin
    if (RES) begin
      eng_q   <= ENG_IDLE;
      host_q  <= 1'b0;
      hwr_q   <= 1'b0;
      ptr_q   <= 20'd0;
      cnt_q   <= 16'd0;
      val_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ra_q    <= 20'd0;
      rdo_q   <= 8'd0;
      hrd_q   <= 8'd0;
      rdoe_q  <= 1'b0;
      ramcs_q <= 1'b0;
      nrwe_q  <= 1'b1;
    end else begin
      eng_q   <= eng_d;
      host_q  <= host_d;
      hwr_q   <= hwr_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ra_q    <= ra_d;
      rdo_q   <= rdo_d;
      hrd_q   <= hrd_d;
      rdoe_q  <= rdoe_d;
      ramcs_q <= ramcs_d;
      nrwe_q  <= nrwe_d;
    end
  end

  assign HRD   = hrd_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign RA    = ra_q;
  assign RDO   = rdo_q;
  assign RDOE  = rdoe_q;
  assign RAMCS = ramcs_q;
  assign nRWE  = nrwe_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: fills, wrap, zero length, abort, host priority, reset.
`timescale 1ns/1ps
module tb_sram_arbiter;

  logic        C7M = 1'b0;
  logic        RES = 1'b1;
  logic [2:0]  S = 3'd0;
  logic        HREQ = 1'b0, HWR = 1'b0;
  logic [19:0] HADDR = 20'd0;
  logic [7:0]  HWD = 8'd0;
  logic [7:0]  HRD;
  logic [19:0] FADDR = 20'd0;
  logic [15:0] FLEN = 16'd0;
  logic [7:0]  FBYTE = 8'd0;
  logic        GO = 1'b0, ABORT = 1'b0;
  logic        BUSY, DONE;
  logic [19:0] RA;
  logic [7:0]  RDO, RDI;
  logic        RDOE, RAMCS, nRWE;

  sram_arbiter dut (
    .C7M(C7M), .RES(RES), .S(S), .HREQ(HREQ), .HWR(HWR), .HADDR(HADDR), .HWD(HWD),
    .HRD(HRD), .FADDR(FADDR), .FLEN(FLEN), .FBYTE(FBYTE), .GO(GO), .ABORT(ABORT),
    .BUSY(BUSY), .DONE(DONE), .RA(RA), .RDO(RDO), .RDI(RDI), .RDOE(RDOE),
    .RAMCS(RAMCS), .nRWE(nRWE)
  );

  always #5 C7M = ~C7M;

  // SRAM read model: contents are a fixed function of the address.
  function automatic logic [7:0] mem_val(input logic [19:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction
  assign RDI = mem_val(RA);

  function automatic logic [19:0] fill_addr(input logic [19:0] base, input int i);
    return 20'((int'(base) + i) % 1048576);
  endfunction

  typedef struct {
    logic [19:0] addr;
    logic [7:0]  data;
    logic [2:0]  s;
    logic        cs;
    logic        oe;
    int          cyc;
  } wr_ev_t;

  typedef struct {
    logic [19:0] addr;
    logic [7:0]  data;
  } hw_t;

  wr_ev_t ev_q[$];
  int cyc = 0;
  int total = 0;
  int bad = 0;

  // Phase counter: s_mode 0 holds s_hold, 1 runs 1..7 then holds 7 for PHI1.
  int s_mode = 0;
  logic [2:0] s_hold = 3'd0;
  int sidx = 0;
  initial begin
    forever begin
      @(posedge C7M);
      #1;
      if (s_mode == 0) S = s_hold;
      else begin
        sidx = (sidx + 1) % 12;
        S = (sidx < 7) ? 3'(sidx + 1) : 3'd7;
      end
    end
  end

  always @(posedge C7M) cyc <= cyc + 1;

  always @(negedge C7M) begin : monitor
    wr_ev_t ev;
    if (nRWE === 1'b0) begin
      ev.addr = RA; ev.data = RDO; ev.s = S; ev.cs = RAMCS; ev.oe = RDOE; ev.cyc = cyc;
      ev_q.push_back(ev);
    end
  end

  task automatic tick();
    @(negedge C7M);
    #1;
  endtask

  task automatic start_fill(input logic [19:0] a, input logic [15:0] n, input logic [7:0] b);
    FADDR = a; FLEN = n; FBYTE = b; GO = 1'b1;
    tick();
    GO = 1'b0;
  endtask

  task automatic test_reset();
    RES = 1'b1; s_mode = 0; s_hold = 3'd0;
    repeat (3) tick();
    total++; if (RA !== 20'd0) begin bad++; $display("FAIL reset_RA got=%h exp=%h", RA, 20'd0); end
    total++; if (RDO !== 8'd0) begin bad++; $display("FAIL reset_RDO got=%h exp=%h", RDO, 8'd0); end
    total++; if (HRD !== 8'd0) begin bad++; $display("FAIL reset_HRD got=%h exp=%h", HRD, 8'd0); end
    total++; if (RDOE !== 1'b0) begin bad++; $display("FAIL reset_RDOE got=%b exp=0", RDOE); end
    total++; if (RAMCS !== 1'b0) begin bad++; $display("FAIL reset_RAMCS got=%b exp=0", RAMCS); end
    total++; if (nRWE !== 1'b1) begin bad++; $display("FAIL reset_nRWE got=%b exp=1", nRWE); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_BUSY got=%b exp=0", BUSY); end
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL reset_DONE got=%b exp=0", DONE); end
    RES = 1'b0;
    s_hold = 3'd7;
    repeat (2) tick();
  endtask

  task automatic test_basic_fill();
    ev_q.delete();
    start_fill(20'h00010, 16'd4, 8'hA5);
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL basic_busy_after_go got=%b exp=1", BUSY); end
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL basic_done_after_go got=%b exp=0", DONE); end
    for (int i = 0; i < 100 && BUSY === 1'b1; i++) tick();
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b exp=0", BUSY); end
    total++; if (DONE !== 1'b1) begin bad++; $display("FAIL basic_done_end got=%b exp=1", DONE); end
    total++; if (ev_q.size() != 4) begin bad++; $display("FAIL basic_count got=%0d exp=4", ev_q.size()); end
    for (int i = 0; i < ev_q.size() && i < 4; i++) begin
      total++;
      if (ev_q[i].addr !== fill_addr(20'h00010, i) || ev_q[i].data !== 8'hA5 ||
          ev_q[i].cs !== 1'b1 || ev_q[i].oe !== 1'b1) begin
        bad++;
        $display("FAIL basic_write%0d got=%h/%h cs=%b oe=%b exp=%h/a5 cs=1 oe=1", i,
                 ev_q[i].addr, ev_q[i].data, ev_q[i].cs, ev_q[i].oe, fill_addr(20'h00010, i));
      end
      if (i > 0) begin
        total++;
        if (ev_q[i].cyc - ev_q[i-1].cyc != 2) begin
          bad++;
          $display("FAIL basic_spacing%0d got=%0d exp=2", i, ev_q[i].cyc - ev_q[i-1].cyc);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] b;
    b = 8'($urandom);
    ev_q.delete();
    start_fill(20'hFFFFE, 16'd4, b);
    for (int i = 0; i < 100 && BUSY === 1'b1; i++) tick();
    total++; if (ev_q.size() != 4) begin bad++; $display("FAIL wrap_count got=%0d exp=4", ev_q.size()); end
    for (int i = 0; i < ev_q.size() && i < 4; i++) begin
      total++;
      if (ev_q[i].addr !== fill_addr(20'hFFFFE, i) || ev_q[i].data !== b) begin
        bad++;
        $display("FAIL wrap_write%0d got=%h/%h exp=%h/%h", i, ev_q[i].addr, ev_q[i].data,
                 fill_addr(20'hFFFFE, i), b);
      end
    end
    total++; if (DONE !== 1'b1) begin bad++; $display("FAIL wrap_done got=%b exp=1", DONE); end
  endtask

  task automatic test_zero_len();
    int cs_seen;
    logic [19:0] a;
    logic [7:0] b;
    ev_q.delete();
    cs_seen = 0;
    start_fill(20'h00055, 16'd0, 8'h77);
    total++; if (BUSY !== 1'b1 || DONE !== 1'b0) begin bad++; $display("FAIL zero_go got busy=%b done=%b exp busy=1 done=0", BUSY, DONE); end
    tick();
    total++; if (BUSY !== 1'b0 || DONE !== 1'b1) begin bad++; $display("FAIL zero_done got busy=%b done=%b exp busy=0 done=1", BUSY, DONE); end
    for (int i = 0; i < 10; i++) begin
      if (RAMCS !== 1'b0) cs_seen++;
      tick();
    end
    total++; if (cs_seen != 0 || ev_q.size() != 0) begin bad++; $display("FAIL zero_no_access got cs=%0d writes=%0d exp 0/0", cs_seen, ev_q.size()); end

    a = 20'($urandom);
    b = 8'($urandom);
    ev_q.delete();
    start_fill(a, 16'd10, b);
    tick();
    start_fill(a ^ 20'h0F0F0, 16'd3, ~b);
    for (int i = 0; i < 200 && BUSY === 1'b1; i++) tick();
    total++; if (ev_q.size() != 10) begin bad++; $display("FAIL ignore_go_count got=%0d exp=10", ev_q.size()); end
    for (int i = 0; i < ev_q.size() && i < 10; i++) begin
      total++;
      if (ev_q[i].addr !== fill_addr(a, i) || ev_q[i].data !== b) begin
        bad++;
        $display("FAIL ignore_go_write%0d got=%h/%h exp=%h/%h", i, ev_q[i].addr, ev_q[i].data, fill_addr(a, i), b);
      end
    end
    total++; if (DONE !== 1'b1) begin bad++; $display("FAIL ignore_go_done got=%b exp=1", DONE); end
  endtask

  task automatic test_abort();
    logic [19:0] a;
    logic found;
    a = 20'($urandom);
    found = 1'b0;
    ev_q.delete();
    start_fill(a, 16'd10, 8'h3E);
    for (int i = 0; i < 100 && !found; i++) begin
      if (nRWE === 1'b0 && ev_q.size() == 3) found = 1'b1;
      else tick();
    end
    total++; if (!found) begin bad++; $display("FAIL abort_reach_byte3 got=timeout exp=strobe"); end
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    total++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin bad++; $display("FAIL abort_flags got busy=%b done=%b exp busy=0 done=0", BUSY, DONE); end
    repeat (20) tick();
    total++; if (ev_q.size() != 3) begin bad++; $display("FAIL abort_count got=%0d exp=3", ev_q.size()); end
    if (ev_q.size() >= 3) begin
      total++;
      if (ev_q[2].addr !== fill_addr(a, 2) || ev_q[2].data !== 8'h3E) begin
        bad++;
        $display("FAIL abort_byte3 got=%h/%h exp=%h/3e", ev_q[2].addr, ev_q[2].data, fill_addr(a, 2));
      end
    end
    total++; if (RAMCS !== 1'b0 || BUSY !== 1'b0) begin bad++; $display("FAIL abort_quiet got cs=%b busy=%b exp 0/0", RAMCS, BUSY); end
  endtask

  task automatic test_host_during_fill();
    hw_t hw_q[$];
    hw_t h;
    wr_ev_t eng[$];
    wr_ev_t hst[$];
    logic [19:0] a, h_addr;
    logic [7:0] b;
    logic host_frame, pend_rd, finished;
    int viol, reads;
    a = 20'($urandom);
    b = 8'($urandom);
    h_addr = 20'd0;
    host_frame = 1'b0; pend_rd = 1'b0; finished = 1'b0;
    viol = 0; reads = 0;
    s_mode = 1;
    tick();
    ev_q.delete();
    start_fill(a, 16'd100, b);
    for (int i = 0; i < 3000 && !finished; i++) begin
      if (S >= 3'd4 && S <= 3'd6) begin
        if (host_frame) begin
          if (RAMCS !== 1'b1 || RA !== h_addr) viol++;
        end else if (RAMCS !== 1'b0) viol++;
      end
      if (S == 3'd7) begin
        if (pend_rd) begin
          total++;
          if (HRD !== mem_val(h_addr)) begin
            bad++;
            $display("FAIL host_read addr=%h got=%h exp=%h", h_addr, HRD, mem_val(h_addr));
          end
          reads++;
        end
        pend_rd = 1'b0;
        host_frame = 1'b0;
      end
      if (BUSY !== 1'b1 && S == 3'd1 && !pend_rd) finished = 1'b1;
      HREQ = finished ? 1'b0 : 1'($urandom_range(0, 1));
      HWR = 1'($urandom_range(0, 1));
      HADDR = 20'($urandom);
      HWD = 8'($urandom);
      if (S == 3'd3 && HREQ) begin
        host_frame = 1'b1;
        h_addr = HADDR;
        if (HWR) begin h.addr = HADDR; h.data = HWD; hw_q.push_back(h); end
        else pend_rd = 1'b1;
      end
      if (!finished) tick();
    end
    HREQ = 1'b0;
    total++; if (!finished) begin bad++; $display("FAIL host_fill_timeout got busy=%b exp=0", BUSY); end
    total++; if (DONE !== 1'b1) begin bad++; $display("FAIL host_fill_done got=%b exp=1", DONE); end
    total++; if (viol != 0) begin bad++; $display("FAIL host_window got=%0d violations exp=0", viol); end
    foreach (ev_q[k]) begin
      if (ev_q[k].s == 3'd5) hst.push_back(ev_q[k]);
      else eng.push_back(ev_q[k]);
    end
    total++; if (eng.size() != 100) begin bad++; $display("FAIL host_fill_count got=%0d exp=100", eng.size()); end
    for (int i = 0; i < eng.size() && i < 100; i++) begin
      total++;
      if (eng[i].addr !== fill_addr(a, i) || eng[i].data !== b) begin
        bad++;
        $display("FAIL host_fill_write%0d got=%h/%h exp=%h/%h", i, eng[i].addr, eng[i].data, fill_addr(a, i), b);
      end
    end
    total++; if (hst.size() != hw_q.size()) begin bad++; $display("FAIL host_write_count got=%0d exp=%0d", hst.size(), hw_q.size()); end
    for (int i = 0; i < hst.size() && i < hw_q.size(); i++) begin
      total++;
      if (hst[i].addr !== hw_q[i].addr || hst[i].data !== hw_q[i].data || hst[i].oe !== 1'b1) begin
        bad++;
        $display("FAIL host_write%0d got=%h/%h oe=%b exp=%h/%h oe=1", i, hst[i].addr, hst[i].data, hst[i].oe, hw_q[i].addr, hw_q[i].data);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic found;
    found = 1'b0;
    s_mode = 0; s_hold = 3'd7;
    repeat (2) tick();
    ev_q.delete();
    start_fill(20'h00200, 16'd5, 8'hC3);
    for (int i = 0; i < 20 && !found; i++) begin
      if (RAMCS === 1'b1 && nRWE === 1'b1) found = 1'b1;
      else tick();
    end
    total++; if (!found) begin bad++; $display("FAIL rstmid_setup got=timeout exp=setup"); end
    RES = 1'b1;
    tick();
    total++; if (RAMCS !== 1'b0 || nRWE !== 1'b1 || RDOE !== 1'b0) begin bad++; $display("FAIL rstmid_strobes got cs=%b nwe=%b oe=%b exp 0/1/0", RAMCS, nRWE, RDOE); end
    total++; if (RA !== 20'd0 || RDO !== 8'd0 || HRD !== 8'd0) begin bad++; $display("FAIL rstmid_data got ra=%h rdo=%h hrd=%h exp 0", RA, RDO, HRD); end
    total++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin bad++; $display("FAIL rstmid_flags got busy=%b done=%b exp 0/0", BUSY, DONE); end
    RES = 1'b0;
    repeat (10) tick();
    total++; if (ev_q.size() != 0 || RAMCS !== 1'b0 || BUSY !== 1'b0) begin bad++; $display("FAIL rstmid_no_resume got writes=%0d cs=%b busy=%b exp 0/0/0", ev_q.size(), RAMCS, BUSY); end
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_wrap();
    test_zero_len();
    test_abort();
    test_host_during_fill();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
